// File: rtl/l2_array_sweeper_if.sv
// l2_array_sweeper_if: sweep control, array access and downstream entry stream.
//   start, busy, done              : sweep request and status
//   arr_index, arr_dataout         : array read port (combinational read)
//   arr_load, arr_datain           : array write port (clear path)
//   out_valid, out_ready           : downstream valid/ready handshake
//   out_index, out_data            : presented entry
// Modport master is the sweeper side; slave is the environment side.
interface l2_array_sweeper_if #(
  parameter int unsigned s_index = 3,
  parameter int unsigned width   = 1
);
  logic               start;
  logic               busy;
  logic               done;
  logic [s_index-1:0] arr_index;
  logic [width-1:0]   arr_dataout;
  logic               arr_load;
  logic [width-1:0]   arr_datain;
  logic               out_valid;
  logic               out_ready;
  logic [s_index-1:0] out_index;
  logic [width-1:0]   out_data;

  modport master (
    input  start, arr_dataout, out_ready,
    output busy, done, arr_index, arr_load, arr_datain,
           out_valid, out_index, out_data
  );

  modport slave (
    output start, arr_dataout, out_ready,
    input  busy, done, arr_index, arr_load, arr_datain,
           out_valid, out_index, out_data
  );
endinterface

// File: rtl/l2_array_sweeper.sv
// l2_array_sweeper: walks every set of an attached array once per start
// request, presenting each entry downstream on a valid/ready stream.
// Each entry costs one READ cycle plus at least one WAIT cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : l2_array_sweeper_if.master (control, array port, entry stream)
// Optional feature: define L2_SWEEP_CLEAR_EN to zero each entry in the array
// in the same cycle it is accepted downstream; otherwise the sweep is read-only.
module l2_array_sweeper #(
  parameter int unsigned s_index = 3,
  parameter int unsigned width   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_array_sweeper_if.master    bus
);

  // Last set index (num_sets - 1); the counter stops here and never wraps.
  localparam logic [s_index-1:0] last_idx = {s_index{1'b1}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [s_index-1:0] cnt, cnt_nxt;
  logic [s_index-1:0] oidx, oidx_nxt;
  logic [width-1:0]   odata, odata_nxt;
  logic               ovalid, ovalid_nxt;
  logic               done_q, done_nxt;
  logic               busy_q, busy_nxt;
  logic               hs_c;

  // Downstream acceptance of the presented entry.
  assign hs_c = (state == WAIT) && ovalid && bus.out_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      oidx   <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      oidx   <= oidx_nxt;
      odata  <= odata_nxt;
      ovalid <= ovalid_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    oidx_nxt   = oidx;
    odata_nxt  = odata;
    ovalid_nxt = ovalid;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          cnt_nxt   = '0;
          state_nxt = READ;
        end
      end
      READ: begin
        odata_nxt  = bus.arr_dataout;
        oidx_nxt   = cnt;
        ovalid_nxt = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (hs_c) begin
          ovalid_nxt = 1'b0;
          if (cnt == last_idx) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt   = cnt + s_index'(1);
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // busy tracks the state being entered so it is registered, not decoded.
    busy_nxt = (state_nxt == READ) || (state_nxt == WAIT);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.arr_index  = cnt;
  assign bus.arr_datain = '0;
  assign bus.out_valid  = ovalid;
  assign bus.out_index  = oidx;
  assign bus.out_data   = odata;

`ifdef L2_SWEEP_CLEAR_EN
  // Zero the accepted entry at the handshake edge; IDLE during reset keeps it low.
  assign bus.arr_load = hs_c;
`else
  assign bus.arr_load = 1'b0;
`endif

endmodule
